pipe_ctl: RTL
=============

// Module: pipe_ctl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage IF/ID/EX/MEM/WB core.
//  Decides per cycle whether PC and ID hold, whether EX receives a bubble, and whether ID is squashed after a taken branch.
//  Drives the rs/rt forwarding muxes in front of the ALU.
//  Sequences the fatal-exception drain and the halt.
// PARAMETERS
//  REG_AW        5   register index width
//  EXC_W         8   exception code width
//  BR_FLUSH      1   cycles ID is squashed after br_enable
//  DRAIN_CYCLES  3   cycles to drain EX/MEM/WB before HALTED
//  CNT_W         32  statistics counter width
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-low reset
//  id_rs        in   REG_AW  ID source register rs
//  id_rt        in   REG_AW  ID source register rt
//  id_use_rs    in   1       ID instruction reads rs
//  id_use_rt    in   1       ID instruction reads rt
//  ex_rd        in   REG_AW  EX destination register
//  ex_wen       in   1       EX writes a register
//  ex_load      in   1       EX instruction is a load (mem2reg_en_d0)
//  mem_rd       in   REG_AW  MEM destination register (rd_d1)
//  mem_wen      in   1       MEM writes a register (reg_write_en_d1)
//  wb_exc       in   EXC_W   WB exception code
//  br_enable    in   1       EX resolved a taken branch
//  pc_stall     out  1       hold pc_id
//  id_stall     out  1       hold the ID instruction and its decode
//  ex_bubble    out  1       zero EX write enables (reg, mem, br)
//  id_flush     out  1       squash the ID instruction
//  fwd_rs_sel   out  2       0 = regfile, 1 = EX/MEM alu_out, 2 = MEM/WB data
//  fwd_rt_sel   out  2       same encoding as fwd_rs_sel, for rt
//  halted       out  1       sticky halt
//  state        out  3       FSM state, for debug
//  stat_stalls  out  CNT_W   load-use stall cycles
//  stat_flushes out  CNT_W   branch flush cycles
// BEHAVIOUR
//  Reset
//   - State RUN; every output 0; flush counter and drain counter 0.
//   - Reset asserted mid-operation clears everything immediately, including HALTED.
//  Register $0
//   - Never produces a hazard and is never forwarded.
//  Forwarding (combinational, every cycle, any state)
//   - rs: sel=1 if ex_wen && !ex_load && ex_rd==id_rs.
//   - else sel=2 if mem_wen && mem_rd==id_rs.
//   - else sel=0. EX beats MEM (youngest wins).
//   - rt: same rules with id_rt.
//  Load-use (combinational)
//   - luse = ex_load && ex_rd!=0 && ((id_use_rs && ex_rd==id_rs) || (id_use_rt && ex_rd==id_rt)).
//  FSM states
//   - RUN: evaluated in priority order.
//     - Fatal exception (wb_exc!=0 and wb_exc!=TRAP_STALL): go to DRAIN.
//     - br_enable: id_flush=1 this cycle; go to FLUSH if BR_FLUSH>1.
//     - luse: pc_stall=id_stall=ex_bubble=1 for exactly one cycle; the load then forwards via sel=2.
//     - wb_exc==TRAP_STALL: pc_stall=id_stall=1 this cycle only; no state change.
//   - FLUSH: id_flush=1; counts to BR_FLUSH-1, then returns to RUN.
//   - DRAIN: pc_stall=id_stall=id_flush=1; counts DRAIN_CYCLES, then HALTED.
//   - HALTED: halted=1; pc_stall=id_stall=id_flush=ex_bubble=1; leaves only on reset.
//  Simultaneous events
//   - br_enable with luse: branch wins and no stall is taken; the squashed instruction needs no stall.
//   - Fatal exception beats everything, including an in-progress FLUSH.
//  Stall outputs
//   - Combinational from inputs and registered state; zero-cycle latency, no registered lag.
//  Statistics counters
//   - Wrap at 2^CNT_W.
//   - stat_stalls increments per luse stall cycle.
//   - stat_flushes increments per id_flush cycle in RUN or FLUSH.
// CONFIGURATION
//  PIPE_CTL_STATS_EN
//   - Defined: both counters implemented as above.
//   - Undefined: counters removed; stat_stalls and stat_flushes tied to 0. Ports stay, for a stable interface.
// STRUCTURE
//  Shared package pipe_ctl_pkg holds:
//   - state encodings RUN=0, FLUSH=1, DRAIN=2, HALTED=3;
//   - FWD_REG/FWD_EX/FWD_WB constants;
//   - TRAP_STALL and the exception code definitions.
//  Sub-module pipe_fwd_unit: pure-combinational compare for one source register, instantiated twice (rs, rt).
// TESTING
//  - add $3 in EX (ex_wen=1, ex_rd=3), ID reads rs=3 -> fwd_rs_sel=1, no stall.
//  - lw $4 in EX (ex_load=1), ID use_rt, rt=4 -> one cycle of pc_stall=id_stall=ex_bubble=1, stat_stalls 0->1; next cycle mem_rd=4 gives fwd_rt_sel=2.
//  - ex_rd=mem_rd=5, both write enables set, id_rs=5 -> fwd_rs_sel=1; id_rs=0 with ex_rd=0 -> sel=0, no stall.
//  - br_enable=1 and luse=1 in the same cycle -> id_flush=1, pc_stall=0, stat_stalls unchanged.
//  - wb_exc=TRAP_STALL for one cycle -> stall that cycle only, state stays RUN.
//  - wb_exc=8'h01 -> DRAIN for 3 cycles, then halted=1; drop rst mid-DRAIN -> all outputs 0, state RUN, asynchronously.

Source files
------------

// File: rtl/pipe_ctl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctl_pkg : shared state encodings, forwarding selects, exception codes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_ctl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HALTED = 3'd3
  } state_t;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Any nonzero code other than TRAP_STALL is fatal.
  localparam logic [7:0] EXC_NONE     = 8'h00;
  localparam logic [7:0] EXC_ILLEGAL  = 8'h01;
  localparam logic [7:0] EXC_OVERFLOW = 8'h02;
  localparam logic [7:0] EXC_ADDR     = 8'h03;
  localparam logic [7:0] TRAP_STALL   = 8'h80;

endpackage

`default_nettype wire

// File: rtl/pipe_fwd_unit.sv
// ---------------------------------------------------------------------------
// pipe_fwd_unit : forwarding select and load hit for one ID source register
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_fwd_unit
  import pipe_ctl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wen,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wen,
  output logic [1:0]        sel,
  output logic              load_hit
);

  logic w_nz;
  assign w_nz = (src != '0);

  // EX is younger than MEM, so it takes priority; a load in EX has no data yet.
  always_comb begin
    sel = FWD_REG;
    if (w_nz && ex_wen && !ex_load && (ex_rd == src))
      sel = FWD_EX;
    else if (w_nz && mem_wen && (mem_rd == src))
      sel = FWD_WB;
  end

  assign load_hit = w_nz && ex_load && (ex_rd == src);

endmodule

`default_nettype wire

// File: rtl/pipe_ctl.sv
// ---------------------------------------------------------------------------
// pipe_ctl : hazard/flush/drain controller; PIPE_CTL_STATS_EN adds counters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int EXC_W        = 8,
  parameter int BR_FLUSH     = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wen,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wen,
  input  logic [EXC_W-1:0]  wb_exc,
  input  logic              br_enable,
  output logic              pc_stall,
  output logic              id_stall,
  output logic              ex_bubble,
  output logic              id_flush,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic              halted,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  stat_stalls,
  output logic [CNT_W-1:0]  stat_flushes
);

  localparam logic [7:0] FLUSH_LAST = 8'((BR_FLUSH > 1) ? (BR_FLUSH - 2) : 0);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_flush_cnt, w_flush_cnt_nxt;
  logic [7:0] r_drain_cnt, w_drain_cnt_nxt;
  logic       w_rs_load, w_rt_load, w_luse, w_trap, w_fatal;

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_rs (
    .src      (id_rs),
    .ex_rd    (ex_rd),
    .ex_wen   (ex_wen),
    .ex_load  (ex_load),
    .mem_rd   (mem_rd),
    .mem_wen  (mem_wen),
    .sel      (fwd_rs_sel),
    .load_hit (w_rs_load)
  );

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_rt (
    .src      (id_rt),
    .ex_rd    (ex_rd),
    .ex_wen   (ex_wen),
    .ex_load  (ex_load),
    .mem_rd   (mem_rd),
    .mem_wen  (mem_wen),
    .sel      (fwd_rt_sel),
    .load_hit (w_rt_load)
  );

  assign w_luse  = (id_use_rs && w_rs_load) || (id_use_rt && w_rt_load);
  assign w_trap  = (wb_exc == EXC_W'(TRAP_STALL));
  assign w_fatal = (wb_exc != '0) && !w_trap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    pc_stall        = 1'b0;
    id_stall        = 1'b0;
    ex_bubble       = 1'b0;
    id_flush        = 1'b0;
    halted          = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_fatal) begin
          w_state_nxt     = ST_DRAIN;
          w_drain_cnt_nxt = '0;
        end else if (br_enable) begin
          // The squashed instruction cannot need a load-use stall.
          id_flush = 1'b1;
          if (BR_FLUSH > 1) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = '0;
          end
        end else if (w_luse) begin
          pc_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_bubble = 1'b1;
        end else if (w_trap) begin
          pc_stall = 1'b1;
          id_stall = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (w_fatal) begin
          w_state_nxt     = ST_DRAIN;
          w_drain_cnt_nxt = '0;
        end else begin
          id_flush = 1'b1;
          if (r_flush_cnt == FLUSH_LAST)
            w_state_nxt = ST_RUN;
          else
            w_flush_cnt_nxt = r_flush_cnt + 8'd1;
        end
      end
      ST_DRAIN: begin
        pc_stall = 1'b1;
        id_stall = 1'b1;
        id_flush = 1'b1;
        if (r_drain_cnt == DRAIN_LAST)
          w_state_nxt = ST_HALTED;
        else
          w_drain_cnt_nxt = r_drain_cnt + 8'd1;
      end
      ST_HALTED: begin
        pc_stall  = 1'b1;
        id_stall  = 1'b1;
        id_flush  = 1'b1;
        ex_bubble = 1'b1;
        halted    = 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign state = r_state;

`ifdef PIPE_CTL_STATS_EN
  logic             w_stall_inc, w_flush_inc;
  logic [CNT_W-1:0] r_stat_stalls, r_stat_flushes;

  assign w_stall_inc = (r_state == ST_RUN) && !w_fatal && !br_enable && w_luse;
  assign w_flush_inc = id_flush && ((r_state == ST_RUN) || (r_state == ST_FLUSH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_stalls  <= '0;
      r_stat_flushes <= '0;
    end else begin
      if (w_stall_inc) r_stat_stalls  <= r_stat_stalls + 1'b1;
      if (w_flush_inc) r_stat_flushes <= r_stat_flushes + 1'b1;
    end
  end

  assign stat_stalls  = r_stat_stalls;
  assign stat_flushes = r_stat_flushes;
`else
  assign stat_stalls  = '0;
  assign stat_flushes = '0;
`endif

endmodule

`default_nettype wire
